// File: rtl/stim_loader.sv
// Host byte-stream parser: splits framed opcodes into STIM_FIFO vector words
// and DI_FIFO mux-setup words, with back-pressure from both FIFOs.
module stim_loader #(
  parameter int STF_WIDTH     = 24,
  parameter int CMD_EXT_WIDTH = 8,
  parameter int DIF_WIDTH     = CMD_EXT_WIDTH + STF_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [STF_WIDTH-1:0] sfifo_data,
  output logic                 sfifo_wrreq,
  input  logic                 sfifo_wrfull,
  output logic [DIF_WIDTH-1:0] dififo_data,
  output logic                 dififo_wrreq,
  input  logic                 dififo_wrfull,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_opcode,
  output logic [7:0]           err_count
);

  localparam int BYTES = STF_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, GET_COUNT, GET_VEC, PUT_VEC, GET_MUX, PUT_MUX
  } state_t;

  state_t               state_reg, state_next;
  logic [STF_WIDTH-1:0] hold_reg, hold_next;
  logic [BCW-1:0]       byte_cnt_reg, byte_cnt_next;
  logic [8:0]           words_reg, words_next;
  logic [7:0]           err_count_reg, err_count_next;
  logic                 err_pulse_reg, err_pulse_next;
  logic                 ready_en_reg;
  logic                 accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      hold_reg      <= '0;
      byte_cnt_reg  <= '0;
      words_reg     <= '0;
      err_count_reg <= '0;
      err_pulse_reg <= 1'b0;
      ready_en_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hold_reg      <= hold_next;
      byte_cnt_reg  <= byte_cnt_next;
      words_reg     <= words_next;
      err_count_reg <= err_count_next;
      err_pulse_reg <= err_pulse_next;
      ready_en_reg  <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    hold_next      = hold_reg;
    byte_cnt_next  = byte_cnt_reg;
    words_next     = words_reg;
    err_count_next = err_count_reg;
    err_pulse_next = 1'b0;
    sfifo_wrreq    = 1'b0;
    dififo_wrreq   = 1'b0;
    frame_done     = 1'b0;
    // ready_en_reg keeps in_ready low while reset is held and for no longer
    in_ready = ready_en_reg && (state_reg == IDLE || state_reg == GET_COUNT ||
                                state_reg == GET_VEC || state_reg == GET_MUX);
    accept   = in_valid && in_ready;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          byte_cnt_next = '0;
          if (in_data == 8'h01) begin
            state_next = GET_MUX;
          end else if (in_data == 8'h02) begin
            state_next = GET_COUNT;
          end else begin
            err_pulse_next = 1'b1;
            if (err_count_reg != 8'hFF) err_count_next = err_count_reg + 8'd1;
          end
        end
      end
      GET_COUNT: begin
        if (accept) begin
          words_next    = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
          byte_cnt_next = '0;
          state_next    = GET_VEC;
        end
      end
      GET_VEC, GET_MUX: begin
        if (accept) begin
          hold_next = STF_WIDTH'({hold_reg, in_data});
          if (byte_cnt_reg == LAST_BYTE) begin
            byte_cnt_next = '0;
            state_next    = (state_reg == GET_VEC) ? PUT_VEC : PUT_MUX;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
      end
      PUT_VEC: begin
        if (!sfifo_wrfull) begin
          sfifo_wrreq = 1'b1;
          words_next  = words_reg - 9'd1;
          if (words_reg == 9'd1) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = GET_VEC;
          end
        end
      end
      PUT_MUX: begin
        if (!dififo_wrfull) begin
          dififo_wrreq = 1'b1;
          frame_done   = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sfifo_data  = hold_reg;
  assign dififo_data = {CMD_EXT_WIDTH'(8'h01), hold_reg};
  assign busy        = (state_reg != IDLE);
  assign err_opcode  = err_pulse_reg;
  assign err_count   = err_count_reg;

endmodule

// File: tb/tb_stim_loader.sv
// Scoreboard bench for stim_loader: directed frames push expected FIFO words,
// an independent negedge monitor pops and compares on every write strobe.
module tb_stim_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] sfifo_data;
  logic        sfifo_wrreq;
  logic        sfifo_wrfull;
  logic [31:0] dififo_data;
  logic        dififo_wrreq;
  logic        dififo_wrfull;
  logic        busy;
  logic        frame_done;
  logic        err_opcode;
  logic [7:0]  err_count;

  stim_loader dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sfifo_data(sfifo_data), .sfifo_wrreq(sfifo_wrreq), .sfifo_wrfull(sfifo_wrfull),
    .dififo_data(dififo_data), .dififo_wrreq(dififo_wrreq), .dififo_wrfull(dififo_wrfull),
    .busy(busy), .frame_done(frame_done), .err_opcode(err_opcode), .err_count(err_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_s[$];
  exp_t exp_d[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int s_writes = 0;
  int d_writes = 0;
  int err_pulses = 0;
  int last_s_cyc = 0;
  int prev_s_cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Monitor: independent of the stimulus, compares every FIFO write
  always @(negedge clock) begin
    exp_t e;
    if (sfifo_wrreq && dififo_wrreq) check("exclusive_wrreq", 32'd1, 32'd0);
    if (sfifo_wrreq) begin
      s_writes++;
      prev_s_cyc = last_s_cyc;
      last_s_cyc = cyc;
      if (exp_s.size() == 0) begin
        check("sfifo_unexpected", {8'h0, sfifo_data}, 32'hFFFFFFFF);
      end else begin
        e = exp_s.pop_front();
        check("sfifo_data", {8'h0, sfifo_data}, e.data);
        check("sfifo_frame_done", {31'h0, frame_done}, {31'h0, e.last});
        $display("sfifo write data=%h frame_done=%0b", sfifo_data, frame_done);
      end
    end
    if (dififo_wrreq) begin
      d_writes++;
      if (exp_d.size() == 0) begin
        check("dififo_unexpected", dififo_data, 32'hFFFFFFFF);
      end else begin
        e = exp_d.pop_front();
        check("dififo_data", dififo_data, e.data);
        check("dififo_frame_done", {31'h0, frame_done}, {31'h0, e.last});
        $display("dififo write data=%h frame_done=%0b", dififo_data, frame_done);
      end
    end
    if (frame_done && !sfifo_wrreq && !dififo_wrreq) check("frame_done_stray", 32'd1, 32'd0);
    if (err_opcode) err_pulses++;
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 2000) begin
      @(posedge clock); #1;
      t++;
    end
    check("idle_reached", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    int e0, sw, dw;
    logic [7:0] kb;
    logic [7:0] bytes_q[$];
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    sfifo_wrfull = 1'b0;
    dififo_wrfull = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_in_ready", {31'h0, in_ready}, 32'd0);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_err_count", {24'h0, err_count}, 32'd0);
    check("reset_err_opcode", {31'h0, err_opcode}, 32'd0);
    check("reset_frame_done", {31'h0, frame_done}, 32'd0);
    reset = 1'b0;
    #1;
    check("ready_before_edge", {31'h0, in_ready}, 32'd0);
    @(posedge clock); #1;
    check("ready_after_edge", {31'h0, in_ready}, 32'd1);

    // SETUP_MUXES frame
    exp_d.push_back('{32'h01AABBCC, 1'b1});
    bytes_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    check("mux_busy_in_put", {31'h0, busy}, 32'd1);
    @(posedge clock); #1;
    check("mux_busy_after", {31'h0, busy}, 32'd0);
    check("mux_write_count", d_writes, 32'd1);

    // VECTORS N=2, back-to-back bytes
    exp_s.push_back('{32'h00112233, 1'b0});
    exp_s.push_back('{32'h00445566, 1'b1});
    bytes_q = '{8'h02, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    wait_idle();
    check("vec2_write_count", s_writes, 32'd2);
    check("vec_word_spacing", last_s_cyc - prev_s_cyc, 32'd4);

    // VECTORS N=1 with STIM_FIFO full for 5 cycles
    exp_s.push_back('{32'h00A1B2C3, 1'b1});
    bytes_q = '{8'h02, 8'h01, 8'hA1, 8'hB2};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    sfifo_wrfull = 1'b1;
    send_byte(8'hC3);
    for (int i = 0; i < 5; i++) begin
      check("full_in_ready", {31'h0, in_ready}, 32'd0);
      check("full_no_wrreq", {31'h0, sfifo_wrreq}, 32'd0);
      @(posedge clock); #1;
    end
    sfifo_wrfull = 1'b0;
    #1;
    check("write_after_release", {31'h0, sfifo_wrreq}, 32'd1);
    wait_idle();
    check("full_write_count", s_writes, 32'd3);

    // Unknown opcode, then a valid DI frame, then saturation
    e0 = err_pulses;
    send_byte(8'h7F);
    check("err_opcode_pulse", {31'h0, err_opcode}, 32'd1);
    check("err_count_one", {24'h0, err_count}, 32'd1);
    check("bad_opcode_idle", {31'h0, busy}, 32'd0);
    @(posedge clock); #1;
    check("err_opcode_single", {31'h0, err_opcode}, 32'd0);
    exp_d.push_back('{32'h01000001, 1'b1});
    bytes_q = '{8'h01, 8'h00, 8'h00, 8'h01};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    wait_idle();
    check("err_pulse_count", err_pulses - e0, 32'd1);
    for (int i = 0; i < 300; i++) send_byte(8'h80 | 8'(i % 128));
    @(posedge clock); #1;
    check("err_count_saturated", {24'h0, err_count}, 32'd255);
    check("err_pulse_total", err_pulses - e0, 32'd301);

    // Reset mid-frame
    sw = s_writes;
    dw = d_writes;
    bytes_q = '{8'h02, 8'h03, 8'h11, 8'h22};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("midreset_err_count", {24'h0, err_count}, 32'd0);
    check("midreset_in_ready", {31'h0, in_ready}, 32'd0);
    check("midreset_busy", {31'h0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    exp_d.push_back('{32'h01123456, 1'b1});
    bytes_q = '{8'h01, 8'h12, 8'h34, 8'h56};
    foreach (bytes_q[i]) send_byte(bytes_q[i]);
    wait_idle();
    check("midreset_no_sfifo", s_writes - sw, 32'd0);
    check("midreset_di_write", d_writes - dw, 32'd1);

    // VECTORS with count byte 00 -> 256 words
    sw = s_writes;
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      exp_s.push_back('{{8'h00, kb, ~kb, kb ^ 8'h5A}, (k == 255)});
    end
    send_byte(8'h02);
    send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      send_byte(kb);
      send_byte(~kb);
      send_byte(kb ^ 8'h5A);
    end
    wait_idle();
    check("n256_write_count", s_writes - sw, 32'd256);
    check("n256_ready_idle", {31'h0, in_ready}, 32'd1);

    repeat (2) @(posedge clock);
    #1;
    check("sfifo_queue_drained", exp_s.size(), 32'd0);
    check("dififo_queue_drained", exp_d.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stim_loader.md
STIM_LOADER -- requirements
Module: stim_loader

Interface
REQ-001 Parameter STF_WIDTH, default 24, width of the stimulus word; SHALL be a multiple of 8.
REQ-002 Parameter CMD_EXT_WIDTH, default 8, width of the DI command field.
REQ-003 Parameter DIF_WIDTH, default CMD_EXT_WIDTH+STF_WIDTH, width of the DI FIFO word.
REQ-004 clock  input  1  single clock for all logic; the design SHALL have exactly one clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_data  input  8  host byte stream.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  byte accepted on a cycle where in_valid and in_ready are both high.
REQ-009 sfifo_data  output  STF_WIDTH  stimulus word to STIM_FIFO.
REQ-010 sfifo_wrreq  output  1  STIM_FIFO write strobe, one cycle per word.
REQ-011 sfifo_wrfull  input  1  STIM_FIFO full.
REQ-012 dififo_data  output  DIF_WIDTH  {cmd, payload} to DI_FIFO, cmd in the MSBs.
REQ-013 dififo_wrreq  output  1  DI_FIFO write strobe.
REQ-014 dififo_wrfull  input  1  DI_FIFO full.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-017 err_opcode  output  1  one-cycle pulse on an unknown opcode.
REQ-018 err_count  output  8  count of unknown opcodes, saturating at 255.

Function
REQ-019 Frame format: opcode byte, then payload; all multi-byte fields are MSB first.
REQ-020 Opcode 0x01 SETUP_MUXES: followed by STF_WIDTH/8 bytes; produces one DI_FIFO word {8'h01, payload}.
REQ-021 Opcode 0x02 VECTORS: followed by count byte N, then N*STF_WIDTH/8 bytes; produces N STIM_FIFO words.
- N=0 means 256.
REQ-022 Any other opcode: err_opcode pulses the following cycle, err_count increments (saturating at 255), FSM stays in IDLE, and no FIFO write occurs.
REQ-023 States and transitions:
- IDLE -> GET_MUX on opcode 0x01.
- IDLE -> GET_COUNT on opcode 0x02.
- GET_COUNT -> GET_VEC on the count byte.
- GET_VEC -> PUT_VEC on the last byte of a word.
- GET_MUX -> PUT_MUX on the last payload byte.
- PUT_VEC -> GET_VEC once written, if words remain; otherwise -> IDLE.
- PUT_MUX -> IDLE once written.
REQ-024 Bytes shift into a holding register MSB first; a byte counter tracks position within the word, and a 9-bit counter holds the number of words remaining.
REQ-025 in_ready SHALL be high in IDLE, GET_COUNT, GET_VEC and GET_MUX, and low in PUT_VEC and PUT_MUX.
REQ-026 In PUT_* states, wrreq asserts only while the target full flag is low; while full, the FSM holds in PUT_* with data stable.
REQ-027 sfifo_data/dififo_data SHALL be driven from the holding register and be valid whenever the corresponding wrreq is high.
REQ-028 Latency: if the FIFO is not full, wrreq is high exactly one cycle after the cycle in which the last byte of a word is accepted.
REQ-029 Throughput: one word per STF_WIDTH/8 + 1 cycles when in_valid is continuously high and the FIFO is not full.
REQ-030 frame_done pulses in the cycle the final wrreq of a frame is issued.
REQ-031 The FIFO full flags SHALL be ignored outside PUT_* states; in_valid without a handshake SHALL have no effect.
REQ-032 sfifo_wrreq and dififo_wrreq SHALL never be high in the same cycle.

Reset
REQ-033 While reset is high, the block SHALL force:
- state to IDLE; holding register, counters and err_count to 0;
- in_ready to 0;
- sfifo_wrreq, dififo_wrreq, busy, frame_done and err_opcode to 0.
REQ-034 After reset, in_ready SHALL go high on the first clock edge after reset deasserts.
REQ-035 Reset mid-frame SHALL discard the partial word and remaining count, with no FIFO write, and the next byte after reset SHALL be parsed as an opcode.

Verification
REQ-036 Bytes 01 AA BB CC -> one dififo_wrreq with dififo_data=32'h01AABBCC; frame_done pulses; busy low afterwards.
REQ-037 Bytes 02 02 11 22 33 44 55 66 -> sfifo_data 24'h112233 then 24'h445566, two sfifo_wrreq pulses, and frame_done on the second.
REQ-038 Send VECTORS N=1 with sfifo_wrfull held high for 5 cycles after the last byte -> in_ready low, no wrreq for 5 cycles, then a single write of the correct word.
REQ-039 Send opcode 7F, then 01 00 00 01 -> err_opcode pulses once, err_count=1, then a DI word 32'h01000001; send 300 bad opcodes -> err_count=255.
REQ-040 Assert reset after 02 03 11 22 -> no writes; after reset, 01 12 34 56 -> DI word 32'h01123456.
REQ-041 Count byte 00 with 768 payload bytes -> exactly 256 STIM_FIFO writes, then IDLE.
